// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its register-file storage.
package fifo_pkg;

    localparam int unsigned DBIT_DEF     = 8;
    localparam int unsigned ADDR_BIT_DEF = 2;

    function automatic int unsigned depth_of(input int unsigned addr_bit);
        return 32'd1 << addr_bit;
    endfunction

    typedef logic [ADDR_BIT_DEF:0] count_t;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DBIT register file: one write port and one registered read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DBIT     = DBIT_DEF,
    parameter int unsigned ADDR_BIT = ADDR_BIT_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                we,
    input  logic [ADDR_BIT-1:0] waddr,
    input  logic [DBIT-1:0]     wdata,
    input  logic                re,
    input  logic [ADDR_BIT-1:0] raddr,
    output logic [DBIT-1:0]     rdata
);

    localparam int unsigned Depth = depth_of(ADDR_BIT);

    logic [DBIT-1:0] mem_q [Depth];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read register returns the pre-write contents on a same-address collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/fifo_sync.sv
// Parametrised synchronous FIFO with occupancy count, level flags, sticky errors
// and a one-cycle registered read path.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int unsigned DBIT     = DBIT_DEF,
    parameter int unsigned ADDR_BIT = ADDR_BIT_DEF,
    parameter int unsigned AF_LEVEL = 3,
    parameter int unsigned AE_LEVEL = 1,
    parameter bit          UseRam   = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DBIT-1:0]     w_data,
    input  logic                wr,
    input  logic                rd,
    input  logic                clr_err,
    output logic [DBIT-1:0]     r_data,
    output logic                rd_valid,
    output logic                empty,
    output logic                full,
    output logic                almost_empty,
    output logic                almost_full,
    output logic [ADDR_BIT:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam int unsigned Depth = depth_of(ADDR_BIT);
    localparam int unsigned CntW  = ADDR_BIT + 1;

    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
    localparam logic [CntW-1:0] AfLevel  = CntW'(AF_LEVEL);
    localparam logic [CntW-1:0] AeLevel  = CntW'(AE_LEVEL);

    if (ADDR_BIT < 1 || ADDR_BIT > 8) begin : g_bad_addr_bit
        $error("fifo_sync: ADDR_BIT must be in 1..8");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > Depth) begin : g_bad_af_level
        $error("fifo_sync: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL >= Depth) begin : g_bad_ae_level
        $error("fifo_sync: AE_LEVEL must be below DEPTH");
    end

    logic [ADDR_BIT-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BIT-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                rd_valid_q;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                wr_acc, rd_acc;

    // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
    always_comb begin
        rd_acc = rd & ~empty;
        wr_acc = wr & (~full | rd_acc);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_BIT'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_BIT'(1);
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // A fresh error in the clearing cycle keeps the flag set.
        overflow_d  = (wr & ~wr_acc) | (overflow_q & ~clr_err);
        underflow_d = (rd & ~rd_acc) | (underflow_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_acc;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    if (UseRam) begin : g_ram
        fifo_ram #(
            .DBIT     (DBIT),
            .ADDR_BIT (ADDR_BIT)
        ) u_ram (
            .clk     (clk),
            .reset_n (reset_n),
            .we      (wr_acc),
            .waddr   (wr_ptr_q),
            .wdata   (w_data),
            .re      (rd_acc),
            .raddr   (rd_ptr_q),
            .rdata   (r_data)
        );
    end else begin : g_inline
        logic [DBIT-1:0] mem_q [Depth];
        logic [DBIT-1:0] r_data_q;

        always_ff @(posedge clk) begin
            if (wr_acc) begin
                mem_q[wr_ptr_q] <= w_data;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_data_q <= '0;
            end else if (rd_acc) begin
                r_data_q <= mem_q[rd_ptr_q];
            end
        end

        assign r_data = r_data_q;
    end

    // Status decodes come only from registered state, never from wr/rd.
    always_comb begin
        empty        = (count_q == '0);
        full         = (count_q == DepthCnt);
        almost_empty = (count_q <= AeLevel);
        almost_full  = (count_q >= AfLevel);
    end

    assign count     = count_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync: queue-based reference model, directed scenarios
// with literal expectations, then randomized traffic.
module tb_fifo_sync;

    localparam int unsigned DBIT     = 8;
    localparam int unsigned ADDR_BIT = 2;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned AF_LEVEL = 3;
    localparam int unsigned AE_LEVEL = 1;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [DBIT-1:0]     w_data;
    logic                wr, rd, clr_err;
    logic [DBIT-1:0]     r_data;
    logic                rd_valid, empty, full, almost_empty, almost_full;
    logic [ADDR_BIT:0]   count;
    logic                overflow, underflow;

    int n_total = 0;
    int n_pass  = 0;

    fifo_sync #(
        .DBIT     (DBIT),
        .ADDR_BIT (ADDR_BIT),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL),
        .UseRam   (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .w_data       (w_data),
        .wr           (wr),
        .rd           (rd),
        .clr_err      (clr_err),
        .r_data       (r_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a plain queue plus last popped word and error bits.
    logic [DBIT-1:0] m_q [$];
    logic [DBIT-1:0] m_rdata = '0;
    bit              m_rdv = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
    bit              m_rd_ok, m_wr_ok;
    int              m_n;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_rdata = '0;
            m_rdv   = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            m_rd_ok = rd && (m_q.size() != 0);
            m_wr_ok = wr && ((m_q.size() < DEPTH) || m_rd_ok);
            m_rdv   = m_rd_ok;
            if (m_rd_ok) m_rdata = m_q.pop_front();
            if (m_wr_ok) m_q.push_back(w_data);
            m_ovf = (wr && !m_wr_ok) || (m_ovf && !clr_err);
            m_udf = (rd && !m_rd_ok) || (m_udf && !clr_err);
        end
    end

    always @(negedge clk) begin
        m_n = m_q.size();
        check("count",        32'(count),        32'(m_n));
        check("empty",        32'(empty),        32'(m_n == 0));
        check("full",         32'(full),         32'(m_n == DEPTH));
        check("almost_empty", 32'(almost_empty), 32'(m_n <= AE_LEVEL));
        check("almost_full",  32'(almost_full),  32'(m_n >= AF_LEVEL));
        check("rd_valid",     32'(rd_valid),     32'(m_rdv));
        check("r_data",       32'(r_data),       32'(m_rdata));
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("underflow",    32'(underflow),    32'(m_udf));
    end

    task automatic step(input bit w, input bit r, input logic [DBIT-1:0] d, input bit c);
        wr      = w;
        rd      = r;
        w_data  = d;
        clr_err = c;
        @(posedge clk);
        #1;
        wr      = 1'b0;
        rd      = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        logic [DBIT-1:0] exp_seq [4];
        int pw, pr;

        reset_n = 1'b0;
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0; w_data = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state.
        check("rst_empty",     32'(empty),        32'd1);
        check("rst_ae",        32'(almost_empty), 32'd1);
        check("rst_full",      32'(full),         32'd0);
        check("rst_count",     32'(count),        32'd0);
        check("rst_r_data",    32'(r_data),       32'h00);
        check("rst_overflow",  32'(overflow),     32'd0);
        check("rst_underflow", 32'(underflow),    32'd0);

        // Fill and order.
        step(1, 0, 8'h11, 0);
        step(1, 0, 8'h22, 0);
        check("fill2_af", 32'(almost_full), 32'd0);
        step(1, 0, 8'h33, 0);
        check("fill3_af",    32'(almost_full), 32'd1);
        check("fill3_count", 32'(count),       32'd3);
        step(1, 0, 8'h44, 0);
        check("fill4_full",  32'(full),  32'd1);
        check("fill4_count", 32'(count), 32'd4);

        // Overflow on full.
        step(1, 0, 8'h55, 0);
        check("ovf_flag",  32'(overflow), 32'd1);
        check("ovf_count", 32'(count),    32'd4);

        exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'h00, 0);
            check("drain_data",  32'(r_data),   32'(exp_seq[i]));
            check("drain_valid", 32'(rd_valid), 32'd1);
        end
        check("drain_empty", 32'(empty), 32'd1);

        // Underflow on empty.
        step(0, 1, 8'h00, 0);
        check("udf_flag",  32'(underflow), 32'd1);
        check("udf_valid", 32'(rd_valid),  32'd0);
        check("udf_data",  32'(r_data),    32'h44);
        step(0, 0, 8'h00, 1);
        check("clr_ovf", 32'(overflow),  32'd0);
        check("clr_udf", 32'(underflow), 32'd0);

        // Simultaneous access on full.
        for (int i = 1; i <= 4; i++) step(1, 0, 8'(i), 0);
        step(1, 1, 8'h66, 0);
        check("simfull_count", 32'(count),    32'd4);
        check("simfull_data",  32'(r_data),   32'h01);
        check("simfull_ovf",   32'(overflow), 32'd0);
        exp_seq = '{8'h02, 8'h03, 8'h04, 8'h66};
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'h00, 0);
            check("simfull_drain", 32'(r_data), 32'(exp_seq[i]));
        end

        // Simultaneous access on empty: no fall-through.
        step(1, 1, 8'h77, 0);
        check("simempty_count", 32'(count),     32'd1);
        check("simempty_udf",   32'(underflow), 32'd1);
        check("simempty_valid", 32'(rd_valid),  32'd0);
        step(0, 1, 8'h00, 1);
        check("simempty_data", 32'(r_data), 32'h77);

        // Wrap-around.
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 8'(k), 0);
            check("wrap_count1", 32'(count), 32'd1);
            step(0, 1, 8'h00, 0);
            check("wrap_data",   32'(r_data), 32'(k));
            check("wrap_count0", 32'(count),  32'd0);
        end
        check("wrap_noerr", 32'({overflow, underflow}), 32'd0);

        // Asynchronous reset mid-operation.
        step(1, 0, 8'hA1, 0);
        step(1, 0, 8'hA2, 0);
        step(1, 0, 8'hA3, 0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        @(posedge clk);
        #3 reset_n = 1'b1;
        step(1, 0, 8'hB1, 0);
        step(0, 1, 8'h00, 0);
        check("arst_data",  32'(r_data), 32'hB1);
        check("arst_count0", 32'(count), 32'd0);

        // Randomized traffic with varying read/write pressure.
        for (int seg = 0; seg < 6; seg++) begin
            unique case (seg % 3)
                0: begin pw = 80; pr = 25; end
                1: begin pw = 25; pr = 80; end
                default: begin pw = 60; pr = 60; end
            endcase
            for (int i = 0; i < 400; i++) begin
                step($urandom_range(99) < pw, $urandom_range(99) < pr,
                     8'($urandom), $urandom_range(15) == 0);
            end
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
- Parametrised synchronous first-in-first-out buffer. It is the successor to the fixed 2-entry UART data buffer.
- Sits between the baud-rate/UART RX path (writer) and the interface/ALU control FSM (reader), or between that FSM and UART TX.
- Adds the following over the previous buffer:
  - true FIFO ordering with a circular buffer;
  - configurable width and depth;
  - simultaneous read/write;
  - occupancy count and almost-full/almost-empty flags;
  - sticky overflow/underflow error flags;
  - a registered read path with a data-valid strobe.

Parameters:
- DBIT, 8: data word width in bits.
- ADDR_BIT, 2: pointer width. Depth DEPTH = 2**ADDR_BIT. Legal range is 1..8.
- AF_LEVEL, 3: almost_full asserts when count >= AF_LEVEL. Must satisfy 1 <= AF_LEVEL <= DEPTH.
- AE_LEVEL, 1: almost_empty asserts when count <= AE_LEVEL. Must satisfy 0 <= AE_LEVEL < DEPTH.

Ports:
- clk, input, 1: system clock. All state changes on rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- w_data, input, DBIT: write data.
- wr, input, 1: write request, one word per cycle while high.
- rd, input, 1: read request, one word per cycle while high.
- clr_err, input, 1: synchronous clear of the sticky error flags.
- r_data, output, DBIT: read data, registered.
- rd_valid, output, 1: one-cycle pulse; r_data holds a newly popped word.
- empty, output, 1: count == 0.
- full, output, 1: count == DEPTH.
- almost_empty, output, 1: count <= AE_LEVEL.
- almost_full, output, 1: count >= AF_LEVEL.
- count, output, ADDR_BIT+1: current occupancy, 0..DEPTH.
- overflow, output, 1: sticky; a write was dropped.
- underflow, output, 1: sticky; a read was dropped.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately without waiting for a clock edge):
  - wr_ptr, rd_ptr, count, r_data, rd_valid, overflow and underflow are all 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Memory contents are not reset and are don't-care.
  - Reset asserted mid-operation discards all stored words; the next cycle after release behaves as an empty FIFO.
- Storage: DEPTH x DBIT register array addressed by wr_ptr/rd_ptr (ADDR_BIT bits each). Pointers increment modulo DEPTH; wrap from DEPTH-1 to 0 is natural overflow of the pointer.
- Write acceptance: wr_acc = wr & (~full | rd_acc). On wr_acc:
  - mem[wr_ptr] <= w_data;
  - wr_ptr increments.
- Read acceptance: rd_acc = rd & ~empty. On rd_acc:
  - r_data <= mem[rd_ptr];
  - rd_ptr increments;
  - rd_valid = 1 in the following cycle.
  - Read latency is 1 clock: data sampled at the edge where rd is accepted is visible after that edge.
- r_data holds its last value when no read is accepted. rd_valid is 0 in every cycle that does not follow an accepted read.
- count update per edge:
  - +1 on wr_acc only;
  - -1 on rd_acc only;
  - unchanged on both or neither.
- Simultaneous rd & wr:
  - Not empty and not full: both are performed and count is unchanged.
  - Full: both are performed (the read frees a slot). count stays DEPTH; no overflow.
  - Empty: only the write is performed (no fall-through). The read is dropped, underflow sets, and count becomes 1.
- Error flags:
  - overflow <= 1 when wr & ~wr_acc.
  - underflow <= 1 when rd & ~rd_acc.
  - Both hold until clr_err.
  - clr_err clears both at the next edge. If a new error occurs in the same cycle as clr_err, the new error wins and the flag stays 1.
- Status flags are combinational decodes of the registered count, so they are glitch-free relative to clk and update in the same cycle as count.
- No combinational path exists from wr/rd to any output.

Decomposition:
- Shared package fifo_pkg:
  - default DBIT/ADDR_BIT constants;
  - a localparam function computing DEPTH from ADDR_BIT;
  - a typedef for the count width.
- One natural sub-module, fifo_ram: a DEPTH x DBIT register file with a write port (we, waddr, wdata) and a registered read port (re, raddr, rdata).
- fifo_sync keeps the pointers, count, flags and errors. It must work identically whether or not fifo_ram is used.

Test Plan:
- Reset then idle: reset_n low for 2 clk then high. Required: empty=1, almost_empty=1, full=0, count=0, r_data=0x00, overflow=0, underflow=0.
- Fill and order check (DBIT=8, ADDR_BIT=2): write 0x11, 0x22, 0x33, 0x44, then read 4 times. Required:
  - full=1 and count=4 after the 4th write; almost_full asserts at count=3.
  - r_data is 0x11, 0x22, 0x33, 0x44 with rd_valid=1 each cycle after rd.
  - empty=1 at the end.
- Overflow/underflow: on the full FIFO, write 0x55. Required: overflow=1, count stays 4, and the next reads still return 0x11 first. Then on an empty FIFO, read. Required: underflow=1, rd_valid stays 0, r_data unchanged. Pulse clr_err; both flags go to 0.
- Simultaneous access:
  - Full FIFO, rd=wr=1 with 0x66: count stays 4, pops the oldest word, and 0x66 becomes the newest.
  - Empty FIFO, rd=wr=1 with 0x77: count=1, underflow=1, and a following read returns 0x77.
- Wrap-around: 10 iterations of write k, read k (k = 0x00..0x09). Required: each read returns k, count alternates 1/0, and the pointers wrap twice without error.
- Reset mid-operation: after 3 writes, assert reset_n low asynchronously between edges. Required: count=0 and empty=1 immediately. After release, the first write/read pair returns the new data only.
